instr_encoder: RTL and testbench

// Packs decoded instruction fields (op select, rs/rt/rd, imm16, target26) into 32-bit MIPS words.

---
 rtl/instr_encoder.sv | 101 ++++++++++
 tb/tb_instr_encoder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into 32-bit MIPS words and streams them
// with incrementing word addresses over a valid/ready port to load instruction memory.
// Ports: clk, reset (async, active-low), clear (sync restart);
//   in_valid/in_ready with opsel, rs, rt, rd, imm, target field bundle;
//   out_valid/out_ready with out_word, out_addr; done, err_illegal status.
module instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        opsel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              done,
  output logic              err_illegal
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [CW-1:0] LAST = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, HOLD, FULL} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] enc;
  logic legal, accept, retire;
  always_comb begin
    enc = '0;
    legal = 1'b1;
    case (opsel)
      5'd0:  enc = {6'h00, rs, rt, rd, 5'h0, 6'h21};
      5'd1:  enc = {6'h00, rs, rt, rd, 5'h0, 6'h23};
      5'd2:  enc = {6'h0D, rs, rt, imm};
      5'd3:  enc = {6'h23, rs, rt, imm};
      5'd4:  enc = {6'h2B, rs, rt, imm};
      5'd5:  enc = {6'h0F, 5'h0, rt, imm};
      5'd6:  enc = {6'h04, rs, rt, imm};
      5'd7:  enc = {6'h05, rs, rt, imm};
      5'd8:  enc = {6'h01, rs, 5'b00001, imm};
      5'd9:  enc = {6'h07, rs, 5'h0, imm};
      5'd10: enc = {6'h06, rs, 5'h0, imm};
      5'd11: enc = {6'h01, rs, 5'b00000, imm};
      5'd12: enc = {6'h02, target};
      5'd13: enc = {6'h03, target};
      5'd14: enc = {6'h00, rs, 5'h0, rd, 5'h0, 6'h09};
      5'd15: enc = {6'h00, rs, 5'h0, 5'h0, 5'h0, 6'h08};
      5'd16: enc = {6'h24, rs, rt, imm};
      5'd17: enc = {6'h25, rs, rt, imm};
      5'd18: enc = {6'h22, rs, rt, imm};
      5'd19: enc = {6'h28, rs, rt, imm};
      5'd20: enc = {6'h29, rs, rt, imm};
      5'd21: enc = {6'h2A, rs, rt, imm};
      default: legal = 1'b0;
    endcase
  end
  assign in_ready = !clear && state != FULL && cnt < LAST && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign retire = out_valid && out_ready;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      out_valid <= 1'b0;
      out_word <= '0;
      out_addr <= BASE;
      done <= 1'b0;
      err_illegal <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      cnt <= '0;
      out_valid <= 1'b0;
      out_word <= '0;
      out_addr <= BASE;
      done <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      if (accept && !legal) err_illegal <= 1'b1;
      if (retire) out_addr <= out_addr + 1'b1;
      if (accept && legal) begin
        out_word <= enc;
        out_valid <= 1'b1;
        cnt <= cnt + 1'b1;
        state <= HOLD;
      end else if (retire) begin
        out_valid <= 1'b0;
        state <= (cnt == LAST) ? FULL : IDLE;
        done <= cnt == LAST;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table-driven encoding checks plus directed handshake, wrap, clear and reset sequences.
module tb_instr_encoder;
  logic clk = 1'b0, reset, clear, in_valid, in_ready, out_valid, out_ready, done, err_illegal;
  logic [4:0] opsel, rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] out_word;
  logic [9:0] out_addr;
  int pass = 0, total = 0;
  instr_encoder #(.ADDR_W(10), .DEPTH(4), .BASE_ADDR(1022)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .opsel(opsel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_addr(out_addr),
    .done(done), .err_illegal(err_illegal)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0] op, s, t, d;
    logic [15:0] i;
    logic [25:0] tg;
    logic [31:0] exp;
  } vec_t;
  vec_t v[22];
  int exp_addr[4] = '{1022, 1023, 0, 1};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic set_fields(input logic [4:0] op, s, t, d, input logic [15:0] i, input logic [25:0] tg);
    opsel = op; rs = s; rt = t; rd = d; imm = i; target = tg;
  endtask
  initial begin
    v[0]  = '{5'd0,  5'd1,  5'd2, 5'd3,  16'h0,    26'h0,   32'h00221821};
    v[1]  = '{5'd1,  5'd1,  5'd2, 5'd3,  16'h0,    26'h0,   32'h00221823};
    v[2]  = '{5'd2,  5'd0,  5'd1, 5'd0,  16'h1234, 26'h0,   32'h34011234};
    v[3]  = '{5'd5,  5'd7,  5'd5, 5'd0,  16'hABCD, 26'h0,   32'h3C05ABCD};
    v[4]  = '{5'd8,  5'd4,  5'd9, 5'd0,  16'hFFFE, 26'h0,   32'h0481FFFE};
    v[5]  = '{5'd11, 5'd4,  5'd9, 5'd0,  16'hFFFE, 26'h0,   32'h0480FFFE};
    v[6]  = '{5'd12, 5'd0,  5'd0, 5'd0,  16'h0,    26'hC00, 32'h08000C00};
    v[7]  = '{5'd13, 5'd0,  5'd0, 5'd0,  16'h0,    26'hC00, 32'h0C000C00};
    v[8]  = '{5'd15, 5'd31, 5'd2, 5'd3,  16'h0,    26'h0,   32'h03E00008};
    v[9]  = '{5'd14, 5'd31, 5'd5, 5'd31, 16'h0,    26'h0,   32'h03E0F809};
    v[10] = '{5'd3,  5'd29, 5'd8, 5'd0,  16'h0010, 26'h0,   32'h8FA80010};
    v[11] = '{5'd4,  5'd29, 5'd8, 5'd0,  16'h0010, 26'h0,   32'hAFA80010};
    v[12] = '{5'd6,  5'd1,  5'd2, 5'd0,  16'h0003, 26'h0,   32'h10220003};
    v[13] = '{5'd7,  5'd1,  5'd2, 5'd0,  16'h0003, 26'h0,   32'h14220003};
    v[14] = '{5'd9,  5'd3,  5'd7, 5'd0,  16'h0005, 26'h0,   32'h1C600005};
    v[15] = '{5'd10, 5'd3,  5'd7, 5'd0,  16'h0005, 26'h0,   32'h18600005};
    v[16] = '{5'd16, 5'd1,  5'd2, 5'd0,  16'h0004, 26'h0,   32'h90220004};
    v[17] = '{5'd17, 5'd1,  5'd2, 5'd0,  16'h0004, 26'h0,   32'h94220004};
    v[18] = '{5'd18, 5'd1,  5'd2, 5'd0,  16'h0004, 26'h0,   32'h88220004};
    v[19] = '{5'd19, 5'd1,  5'd2, 5'd0,  16'h0004, 26'h0,   32'hA0220004};
    v[20] = '{5'd20, 5'd1,  5'd2, 5'd0,  16'h0004, 26'h0,   32'hA4220004};
    v[21] = '{5'd21, 5'd1,  5'd2, 5'd0,  16'h0004, 26'h0,   32'hA8220004};
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_fields(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_out_addr", 32'(out_addr), 1022);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err_illegal), 0);
    reset = 1'b1;
    for (int i = 0; i < 22; i++) begin
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      set_fields(v[i].op, v[i].s, v[i].t, v[i].d, v[i].i, v[i].tg);
      in_valid = 1'b1;
      #1 chk($sformatf("enc%0d_in_ready", i), 32'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("enc%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("enc%0d_word", i), out_word, v[i].exp);
      chk($sformatf("enc%0d_addr", i), 32'(out_addr), 1022);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    set_fields(12, 0, 0, 0, 0, 26'hC00);
    in_valid = 1'b1;
    @(negedge clk);
    chk("stall_j_word", out_word, 32'h08000C00);
    opsel = 5'd13;
    out_ready = 1'b0;
    #1 chk("stall_in_ready", 32'(in_ready), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", k), 32'(out_valid), 1);
      chk($sformatf("stall%0d_word", k), out_word, 32'h08000C00);
      chk($sformatf("stall%0d_addr", k), 32'(out_addr), 1022);
      chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1 chk("unstall_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("jal_word", out_word, 32'h0C000C00);
    chk("jal_addr", 32'(out_addr), 1023);
    @(negedge clk);
    chk("jal_drained", 32'(out_valid), 0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_fields(0, 1, 2, 5'(k), 0, 0);
      @(negedge clk);
      chk($sformatf("depth%0d_word", k), out_word, 32'h00220021 | (k << 11));
      chk($sformatf("depth%0d_addr", k), 32'(out_addr), exp_addr[k]);
    end
    #1 chk("depth_full_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("depth_done", 32'(done), 1);
    chk("depth_valid", 32'(out_valid), 0);
    chk("depth_addr_after", 32'(out_addr), 2);
    chk("depth_done_in_ready", 32'(in_ready), 0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_addr", 32'(out_addr), 1022);
    chk("clr_done", 32'(done), 0);
    set_fields(25, 1, 2, 3, 0, 0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("illegal_valid", 32'(out_valid), 0);
    chk("illegal_err", 32'(err_illegal), 1);
    opsel = 5'd0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_illegal_word", out_word, 32'h00221821);
    chk("post_illegal_addr", 32'(out_addr), 1022);
    chk("post_illegal_err", 32'(err_illegal), 1);
    clear = 1'b1;
    in_valid = 1'b1;
    #1 chk("clr_beats_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clr_beats_valid", 32'(out_valid), 0);
    chk("clr_beats_err", 32'(err_illegal), 0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_valid", 32'(out_valid), 1);
    reset = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_word", out_word, 0);
    chk("async_rst_addr", 32'(out_addr), 1022);
    @(negedge clk);
    reset = 1'b1;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
